// File: rtl/topk_pkg.sv
// Shared types and limits for the top-K arg-max/arg-min ranker.
package topk_pkg;

  // Run-control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Legal range for the number of ranked slots.
  localparam int unsigned K_MIN = 1;
  localparam int unsigned K_MAX = 4;

  // Width of the filled-slot count; must hold 0..K_MAX.
  localparam int unsigned CNT_W = $clog2(K_MAX + 1);

endpackage

// File: rtl/topk_argmax_if.sv
// Streaming input, run control and ranked-result bus of the top-K ranker.
interface topk_argmax_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned K      = 3
);

  logic                        start;
  logic [IDX_W-1:0]            len;
  logic                        mode;
  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_W-1:0]           in_data;
  logic                        busy;
  logic                        done;
  logic [K*IDX_W-1:0]          out_idx;
  logic [K*DATA_W-1:0]         out_val;
  logic [topk_pkg::CNT_W-1:0]  out_count;

  // Producer / consumer of the element stream and results.
  modport master (
    output start, len, mode, in_valid, in_data,
    input  in_ready, busy, done, out_idx, out_val, out_count
  );

  // The ranker itself.
  modport slave (
    input  start, len, mode, in_valid, in_data,
    output in_ready, busy, done, out_idx, out_val, out_count
  );

endinterface

// File: rtl/topk_cmp.sv
// Strict "a is better than b" compare: a > b when mode is 0, a < b when
// mode is 1, under two's-complement or unsigned rules.
module topk_cmp #(
  parameter int unsigned DATA_W = 32,
  parameter bit          SIGNED = 1'b1
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              mode,
  output logic              better
);

  logic gt;
  logic lt;

  if (SIGNED) begin : g_signed
    assign gt = $signed(a) > $signed(b);
    assign lt = $signed(a) < $signed(b);
  end else begin : g_unsigned
    assign gt = a > b;
    assign lt = a < b;
  end

  // Select the ordering; equality is never "better" so ties keep order.
  always_comb begin
    better = mode ? lt : gt;
  end

endmodule

// File: rtl/topk_argmax.sv
// Streaming top-K ranker: accepts len elements, keeps the K best (largest or
// smallest) values with their stream indices, and pulses done at run end.
module topk_argmax
  import topk_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned K      = 3,
  parameter bit          SIGNED = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  topk_argmax_if.slave  bus
);

  if (K < K_MIN || K > K_MAX) begin : g_bad_k
    $error("topk_argmax: K out of range");
  end

  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] K_CNT    = CNT_W'(K);
  localparam logic [CNT_W-1:0] FILL_ONE = CNT_W'(1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   len_q, len_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   fill_q, fill_d;

  logic [DATA_W-1:0]  val_q [K];
  logic [DATA_W-1:0]  val_d [K];
  logic [IDX_W-1:0]   idx_q [K];
  logic [IDX_W-1:0]   idx_d [K];
  logic [K-1:0]       vld_q, vld_d;

  // Per-slot candidate: the new beat at the insertion point, the entry
  // from the slot above for every slot below it.
  logic [DATA_W-1:0]  cand_val [K];
  logic [IDX_W-1:0]   cand_idx [K];
  logic [K-1:0]       cand_vld;
  logic [K-1:0]       better;
  logic [K-1:0]       ins;
  logic               accept;

  assign accept = (state_q == ST_RUN) && bus.in_valid;

  // List is sorted and filled from slot 0, so ins is 0..0 1..1; the first
  // set bit is the insertion point, later set bits shift down by one.
  assign ins = ~vld_q | better;

  for (genvar g = 0; g < K; g++) begin : g_slot
    topk_cmp #(
      .DATA_W (DATA_W),
      .SIGNED (SIGNED)
    ) u_cmp (
      .a      (bus.in_data),
      .b      (val_q[g]),
      .mode   (mode_q),
      .better (better[g])
    );

    if (g == 0) begin : g_head
      assign cand_val[g] = bus.in_data;
      assign cand_idx[g] = cnt_q;
      assign cand_vld[g] = 1'b1;
    end else begin : g_tail
      assign cand_val[g] = ins[g-1] ? val_q[g-1] : bus.in_data;
      assign cand_idx[g] = ins[g-1] ? idx_q[g-1] : cnt_q;
      assign cand_vld[g] = ins[g-1] ? vld_q[g-1] : 1'b1;
    end

    assign bus.out_idx[g*IDX_W +: IDX_W]   = idx_q[g];
    assign bus.out_val[g*DATA_W +: DATA_W] = val_q[g];
  end

  assign bus.in_ready  = (state_q == ST_RUN);
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.out_count = fill_q;

  // Next state, run bookkeeping and ranked-list insertion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    val_d   = val_q;
    idx_d   = idx_q;
    vld_d   = vld_q;

    if (bus.start) begin
      // Start wins in every state: a beat offered in this cycle is dropped.
      len_d   = bus.len;
      mode_d  = bus.mode;
      cnt_d   = '0;
      fill_d  = '0;
      vld_d   = '0;
      for (int unsigned i = 0; i < K; i++) begin
        val_d[i] = '0;
        idx_d[i] = '0;
      end
      state_d = (bus.len == '0) ? ST_DONE : ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept) begin
            for (int unsigned i = 0; i < K; i++) begin
              if (ins[i]) begin
                val_d[i] = cand_val[i];
                idx_d[i] = cand_idx[i];
                vld_d[i] = cand_vld[i];
              end
            end
            cnt_d = cnt_q + IDX_ONE;
            if (fill_q != K_CNT) begin
              fill_d = fill_q + FILL_ONE;
            end
            if (cnt_q == len_q - IDX_ONE) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // State and ranked-list registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      fill_q  <= '0;
      vld_q   <= '0;
      for (int unsigned i = 0; i < K; i++) begin
        val_q[i] <= '0;
        idx_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      vld_q   <= vld_d;
      for (int unsigned i = 0; i < K; i++) begin
        val_q[i] <= val_d[i];
        idx_q[i] <= idx_d[i];
      end
    end
  end

endmodule

// File: tb/tb_topk_argmax.sv
// Bench for topk_argmax: a signed and an unsigned instance share stimulus;
// fixed vectors, hand-written corner sequences and random runs checked
// against a selection-based ranking model.
module tb_topk_argmax;

  localparam int unsigned DW = 32;
  localparam int unsigned IW = 8;
  localparam int unsigned KK = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        mode;
  logic        in_valid;
  logic [31:0] in_data;

  always #5 clk = ~clk;

  topk_argmax_if #(.DATA_W(DW), .IDX_W(IW), .K(KK)) if_s ();
  topk_argmax_if #(.DATA_W(DW), .IDX_W(IW), .K(KK)) if_u ();

  assign if_s.start    = start;
  assign if_s.len      = len;
  assign if_s.mode     = mode;
  assign if_s.in_valid = in_valid;
  assign if_s.in_data  = in_data;
  assign if_u.start    = start;
  assign if_u.len      = len;
  assign if_u.mode     = mode;
  assign if_u.in_valid = in_valid;
  assign if_u.in_data  = in_data;

  topk_argmax #(.DATA_W(DW), .IDX_W(IW), .K(KK), .SIGNED(1'b1)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (if_s)
  );

  topk_argmax #(.DATA_W(DW), .IDX_W(IW), .K(KK), .SIGNED(1'b0)) dut_u (
    .clk (clk),
    .rst (rst),
    .bus (if_u)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endfunction

  function automatic logic [23:0] pi(input int a, input int b, input int c);
    return {8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [95:0] pv(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return {c, b, a};
  endfunction

  // Reference ordering: strict better-than under the chosen number rules.
  function automatic bit better_m(input logic [31:0] a, input logic [31:0] b, input bit sgn, input bit md);
    if (sgn) return md ? ($signed(a) < $signed(b)) : ($signed(a) > $signed(b));
    return md ? (a < b) : (a > b);
  endfunction

  // Repeatedly pick the best not-yet-taken element, earliest index on ties.
  function automatic void model(input logic [31:0] d[$], input bit md, input bit sgn,
                                output logic [23:0] e_idx, output logic [95:0] e_val,
                                output logic [2:0] e_cnt);
    bit taken [256];
    int best;
    int n;
    int m;
    n = d.size();
    m = (n < 3) ? n : 3;
    e_idx = '0;
    e_val = '0;
    e_cnt = 3'(m);
    for (int j = 0; j < 256; j++) taken[j] = 1'b0;
    for (int r = 0; r < m; r++) begin
      best = -1;
      for (int j = 0; j < n; j++) begin
        if (!taken[j] && (best < 0 || better_m(d[j], d[best], sgn, md))) best = j;
      end
      taken[best] = 1'b1;
      e_idx[r*8 +: 8]   = 8'(best);
      e_val[r*32 +: 32] = d[best];
    end
  endfunction

  task automatic chk_res(input string nm, input logic [23:0] eis, input logic [95:0] evs,
                         input logic [23:0] eiu, input logic [95:0] evu, input logic [2:0] ec);
    chk({nm, ".s_idx"}, 96'(if_s.out_idx), 96'(eis));
    chk({nm, ".s_val"}, 96'(if_s.out_val), evs);
    chk({nm, ".s_cnt"}, 96'(if_s.out_count), 96'(ec));
    chk({nm, ".u_idx"}, 96'(if_u.out_idx), 96'(eiu));
    chk({nm, ".u_val"}, 96'(if_u.out_val), evu);
    chk({nm, ".u_cnt"}, 96'(if_u.out_count), 96'(ec));
  endtask

  task automatic chk_idle_zero(input string nm);
    chk({nm, ".busy"},  96'({if_s.busy, if_u.busy}), 96'(0));
    chk({nm, ".ready"}, 96'({if_s.in_ready, if_u.in_ready}), 96'(0));
    chk({nm, ".done"},  96'({if_s.done, if_u.done}), 96'(0));
    chk({nm, ".cnt"},   96'({if_s.out_count, if_u.out_count}), 96'(0));
    chk({nm, ".s_res"}, 96'(if_s.out_val) | 96'(if_s.out_idx), 96'(0));
    chk({nm, ".u_res"}, 96'(if_u.out_val) | 96'(if_u.out_idx), 96'(0));
  endtask

  // One complete run: start, beats (optionally 1-on/1-off), done, hold.
  task automatic run_seq(input string nm, input bit md, input int n, input bit gap,
                         input logic [31:0] d[$], input logic [23:0] eis, input logic [95:0] evs,
                         input logic [23:0] eiu, input logic [95:0] evu, input logic [2:0] ec);
    bit tog;
    int i;
    @(negedge clk);
    start = 1'b1; len = 8'(n); mode = md; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk({nm, ".clr_cnt"}, 96'({if_s.out_count, if_u.out_count}), 96'(0));
    chk({nm, ".clr_val"}, 96'(if_s.out_val), 96'(0));
    if (n == 0) begin
      chk({nm, ".ready0"}, 96'({if_s.in_ready, if_u.in_ready}), 96'(0));
      chk({nm, ".done0"},  96'({if_s.done, if_u.done}), 96'(2'b11));
    end else begin
      i = 0;
      tog = 1'b0;
      while (i < n) begin
        chk({nm, ".ready"}, 96'({if_s.in_ready, if_u.in_ready}), 96'(2'b11));
        chk({nm, ".early_done"}, 96'({if_s.done, if_u.done}), 96'(0));
        if (gap && tog) begin
          in_valid = 1'b0;
        end else begin
          in_valid = 1'b1;
          in_data  = d[i];
          i++;
        end
        tog = ~tog;
        @(negedge clk);
      end
      in_valid = 1'b0;
      chk({nm, ".done"}, 96'({if_s.done, if_u.done}), 96'(2'b11));
    end
    chk_res(nm, eis, evs, eiu, evu, ec);
    @(negedge clk);
    chk({nm, ".done_1cyc"}, 96'({if_s.done, if_u.done}), 96'(0));
    chk({nm, ".idle"},      96'({if_s.busy, if_u.busy}), 96'(0));
    chk_res({nm, ".hold"}, eis, evs, eiu, evu, ec);
  endtask

  typedef struct {
    bit          md;
    int          n;
    bit          gap;
    logic [31:0] d [6];
    logic [23:0] eis;
    logic [95:0] evs;
    logic [23:0] eiu;
    logic [95:0] evu;
    logic [2:0]  ec;
  } vec_t;

  vec_t tbl [7];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] q[$];
    logic [23:0] eis, eiu;
    logic [95:0] evs, evu;
    logic [2:0]  ecs, ecu;
    int          n;
    bit          md, gap;

    rst = 1'b1; start = 1'b0; len = '0; mode = 1'b0; in_valid = 1'b0; in_data = '0;

    // Largest-first, smallest-first, unsigned wrap, empty, gapped, K > len.
    tbl[0] = '{md: 1'b0, n: 5, gap: 1'b0,
               d: '{32'd3, 32'hFFFFFFF9, 32'd9, 32'd9, 32'd1, 32'd0},
               eis: pi(2, 3, 0), evs: pv(32'd9, 32'd9, 32'd3),
               eiu: pi(1, 2, 3), evu: pv(32'hFFFFFFF9, 32'd9, 32'd9), ec: 3'd3};
    tbl[1] = '{md: 1'b1, n: 5, gap: 1'b0,
               d: '{32'd3, 32'hFFFFFFF9, 32'd9, 32'd9, 32'd1, 32'd0},
               eis: pi(1, 4, 0), evs: pv(32'hFFFFFFF9, 32'd1, 32'd3),
               eiu: pi(4, 0, 2), evu: pv(32'd1, 32'd3, 32'd9), ec: 3'd3};
    tbl[2] = '{md: 1'b0, n: 2, gap: 1'b0,
               d: '{32'h80000000, 32'h7FFFFFFF, 32'd0, 32'd0, 32'd0, 32'd0},
               eis: pi(1, 0, 0), evs: pv(32'h7FFFFFFF, 32'h80000000, 32'd0),
               eiu: pi(0, 1, 0), evu: pv(32'h80000000, 32'h7FFFFFFF, 32'd0), ec: 3'd2};
    tbl[3] = '{md: 1'b0, n: 0, gap: 1'b0,
               d: '{32'd5, 32'd6, 32'd7, 32'd0, 32'd0, 32'd0},
               eis: '0, evs: '0, eiu: '0, evu: '0, ec: 3'd0};
    tbl[4] = '{md: 1'b0, n: 4, gap: 1'b1,
               d: '{32'd3, 32'hFFFFFFF9, 32'd9, 32'd9, 32'd0, 32'd0},
               eis: pi(2, 3, 0), evs: pv(32'd9, 32'd9, 32'd3),
               eiu: pi(1, 2, 3), evu: pv(32'hFFFFFFF9, 32'd9, 32'd9), ec: 3'd3};
    tbl[5] = '{md: 1'b0, n: 4, gap: 1'b0,
               d: '{32'd3, 32'hFFFFFFF9, 32'd9, 32'd9, 32'd0, 32'd0},
               eis: pi(2, 3, 0), evs: pv(32'd9, 32'd9, 32'd3),
               eiu: pi(1, 2, 3), evu: pv(32'hFFFFFFF9, 32'd9, 32'd9), ec: 3'd3};
    tbl[6] = '{md: 1'b1, n: 1, gap: 1'b0,
               d: '{32'hFFFFFFFB, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
               eis: pi(0, 0, 0), evs: pv(32'hFFFFFFFB, 32'd0, 32'd0),
               eiu: pi(0, 0, 0), evu: pv(32'hFFFFFFFB, 32'd0, 32'd0), ec: 3'd1};

    repeat (2) @(negedge clk);
    chk_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle_zero("post_reset");

    for (int v = 0; v < 7; v++) begin
      q.delete();
      for (int j = 0; j < tbl[v].n; j++) q.push_back(tbl[v].d[j]);
      run_seq($sformatf("vec%0d", v), tbl[v].md, tbl[v].n, tbl[v].gap, q,
              tbl[v].eis, tbl[v].evs, tbl[v].eiu, tbl[v].evu, tbl[v].ec);
    end

    // Abort after two beats; the beat alongside the restart is dropped.
    @(negedge clk);
    start = 1'b1; len = 8'd5; mode = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 32'd100;
    @(negedge clk);
    in_data = 32'd200;
    @(negedge clk);
    start = 1'b1; len = 8'd3; mode = 1'b0; in_data = 32'd999;
    @(negedge clk);
    start = 1'b0;
    chk("abort.clr_cnt", 96'({if_s.out_count, if_u.out_count}), 96'(0));
    chk("abort.clr_val", 96'(if_s.out_val), 96'(0));
    chk("abort.busy",    96'({if_s.busy, if_u.busy}), 96'(2'b11));
    in_data = 32'd5;
    @(negedge clk);
    in_data = 32'd6;
    @(negedge clk);
    in_data = 32'd4;
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort.done", 96'({if_s.done, if_u.done}), 96'(2'b11));
    chk_res("abort", pi(1, 0, 2), pv(32'd6, 32'd5, 32'd4),
            pi(1, 0, 2), pv(32'd6, 32'd5, 32'd4), 3'd3);
    @(negedge clk);

    // Start issued during the done cycle begins a new run at once.
    @(negedge clk);
    start = 1'b1; len = 8'd1; mode = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rest.done1", 96'({if_s.done, if_u.done}), 96'(2'b11));
    chk_res("rest.first", pi(0, 0, 0), pv(32'd7, 32'd0, 32'd0),
            pi(0, 0, 0), pv(32'd7, 32'd0, 32'd0), 3'd1);
    start = 1'b1; len = 8'd2; mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rest.nodone", 96'({if_s.done, if_u.done}), 96'(0));
    chk("rest.busy",   96'({if_s.busy, if_u.busy}), 96'(2'b11));
    chk("rest.clr",    96'({if_s.out_count, if_u.out_count}), 96'(0));
    in_valid = 1'b1; in_data = 32'd4;
    @(negedge clk);
    in_data = 32'd2;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rest.done2", 96'({if_s.done, if_u.done}), 96'(2'b11));
    chk_res("rest.second", pi(1, 0, 0), pv(32'd2, 32'd4, 32'd0),
            pi(1, 0, 0), pv(32'd2, 32'd4, 32'd0), 3'd2);
    @(negedge clk);

    // Asynchronous reset in the middle of a run: immediate clear, no done.
    @(negedge clk);
    start = 1'b1; len = 8'd4; mode = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 32'd11;
    @(negedge clk);
    in_data = 32'd12;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk_idle_zero("rst_async");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_hold.done", 96'({if_s.done, if_u.done}), 96'(0));
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rst_after.done", 96'({if_s.done, if_u.done}), 96'(0));
      chk("rst_after.busy", 96'({if_s.busy, if_u.busy}), 96'(0));
    end

    // Random runs; alternate tie-heavy small values with full-range words.
    for (int r = 0; r < 40; r++) begin
      n   = $urandom_range(0, 9);
      md  = 1'($urandom_range(0, 1));
      gap = 1'($urandom_range(0, 1));
      q.delete();
      for (int j = 0; j < n; j++) begin
        if (r % 2 == 0) q.push_back(32'($urandom_range(0, 6)) - 32'd3);
        else            q.push_back($urandom);
      end
      model(q, md, 1'b1, eis, evs, ecs);
      model(q, md, 1'b0, eiu, evu, ecu);
      run_seq($sformatf("rnd%0d", r), md, n, gap, q, eis, evs, eiu, evu, ecs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/topk_argmax.md
TOPK_ARGMAX -- requirements
Module: topk_argmax

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter DATA_W, default 32, SHALL set the element width.
REQ-003 Parameter IDX_W, default 8, SHALL set the index width; max elements per run = 2^IDX_W - 1.
REQ-004 Parameter K, default 3, legal 1..4, SHALL set the number of ranked results.
REQ-005 Parameter SIGNED, default 1, SHALL select two's-complement (1) or unsigned (0) comparison.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 start  in  1  single-cycle pulse; latches len and mode and begins a run.
REQ-009 len  in  IDX_W  element count for the run, sampled on start.
REQ-010 mode  in  1  0 = rank largest first; 1 = rank smallest first; sampled on start.
REQ-011 in_valid  in  1  in_data is valid.
REQ-012 in_ready  out  1  block accepts a beat; beat transfers when in_valid && in_ready.
REQ-013 in_data  in  DATA_W  element value.
REQ-014 busy  out  1  high in RUN.
REQ-015 done  out  1  one-cycle pulse at end of run.
REQ-016 out_idx  out  K*IDX_W  ranked indices; slot 0 in bits [IDX_W-1:0] is best.
REQ-017 out_val  out  K*DATA_W  ranked values, same slot order.
REQ-018 out_count  out  3  number of valid slots, min(K, len).

Function
REQ-019 FSM SHALL have states IDLE, RUN and DONE.
REQ-020 IDLE->RUN on start with len != 0; IDLE->DONE on start with len == 0.
REQ-021 RUN->DONE in the cycle after the beat whose zero-based index equals len-1 is accepted; DONE->IDLE after exactly one cycle.
REQ-022 in_ready SHALL equal (state == RUN); beats offered outside RUN are ignored.
REQ-023 Each accepted beat SHALL carry index = count of beats previously accepted in the run, starting at 0.
REQ-024 Each accepted beat SHALL be inserted into a K-entry ranked register list in the same cycle, shifting worse entries down and dropping entry K-1.
REQ-025 "Better" SHALL be a strict > (mode 0) or strict < (mode 1) under SIGNED rules, so ties keep the earlier index ranked higher.
REQ-026 Unfilled slots SHALL be treated as worse than any value and SHALL read idx 0, val 0 at the outputs.
REQ-027 done SHALL be high for exactly the one cycle in DONE; out_idx, out_val and out_count SHALL be valid from that cycle and hold until the next start.
REQ-028 Latency from the last accepted beat to done SHALL be 1 cycle; throughput SHALL be 1 beat per cycle.
REQ-029 start in RUN SHALL abort the current run, clear the list, relatch len and mode, and restart from index 0; a beat in that same cycle SHALL be discarded.
REQ-030 start in DONE SHALL be honoured as a start from IDLE; done still pulses for the completed run.
REQ-031 len == 0 SHALL produce a done pulse with out_count = 0 and no beats accepted.
REQ-032 Result outputs SHALL be cleared on the start cycle.

Reset
REQ-033 On rst, state SHALL go to IDLE and every output, ranked slot, counter and latched len/mode SHALL be 0, independent of clk.
REQ-034 rst mid-run SHALL discard the run with no done pulse.

Structure
REQ-035 Shared package topk_pkg SHALL hold the FSM state type and the K range limit.
REQ-036 Sub-module topk_cmp SHALL implement the mode- and SIGNED-aware strict "better than" compare; K instances SHALL drive the insertion shift.

Verification
REQ-037 K=3, SIGNED=1, mode 0, len 5, data {3,-7,9,9,1} -> done 1 cycle after beat 4; idx {2,3,0}, val {9,9,3}, out_count 3.
REQ-038 mode 1, same data -> idx {1,4,0}, val {-7,1,3}.
REQ-039 SIGNED=0, mode 0, len 2, data {0x80000000, 0x7FFFFFFF} -> idx {0,1}, out_count 2, slot 2 reads idx 0/val 0.
REQ-040 len 0 -> done the cycle after start, out_count 0, in_ready never high.
REQ-041 len 4, in_valid gapped 1-on/1-off -> in_ready held through gaps; done 1 cycle after the 4th transfer; results identical to the gap-free run.
REQ-042 start re-pulsed after 2 beats, then 3 new beats {5,6,4} with len 3 -> idx {1,0,2}; rst asserted mid-run -> outputs 0 and no done pulse.
